uart_cmd_responder: RTL and testbench
=====================================

Name: uart_cmd_responder

Overview:
- Byte-level command/response engine between an external uart_receiver and uart_transmitter.
- Parametrised successor of the single-byte debug responder. Adds a TX byte FIFO, multi-byte status replies, a fourth mode reachable by command, error counting, and a configurable heartbeat.
- Sits in the board top between the HC-05 UART pair and the debug LEDs/status outputs.

Parameters:
CLOCK_FREQ, 50_000_000, clock frequency in Hz.
HB_PERIOD, 50_000_000, heartbeat period in clk cycles; must be ≥2.
FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2 and ≥4.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle
rx_error  in  1  framing error qualifier for rx_valid
tx_data  out  8  byte to transmit
tx_send  out  1  one-cycle transmit request
tx_busy  in  1  transmitter busy
tx_done  in  1  one-cycle strobe; byte finished transmitting
mode  out  2  0=ECHO, 1=FIXED, 2=COUNTER, 3=PATTERN
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky; a response byte was dropped
err_count  out  8  rx_error count, saturating
busy  out  1  push FSM or TX FSM not idle, or FIFO not empty

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous and active-high.
- Reset values: all outputs 0, mode=ECHO, FIFO empty, counter=0, pattern=0x55, both FSMs idle, pending slot empty.
- Accepted byte: rx_valid && !rx_error. Error byte: rx_valid && rx_error.
- Error byte handling: err_count += 1, saturating at 0xFF. No response is generated.
- Command decode happens in the cycle after acceptance. Each response byte is pushed to the FIFO, one byte per cycle.
- 'P' → 'O' (0x4F).
- 'E'/'F'/'C'/'T' → set mode to 0/1/2/3, respond 'A' (0x41).
- 'R' → counter=0, err_count=0, overflow=0, respond 'A'.
- 'S' → 4 bytes in order: 0x53, {6'b0,mode}, counter, err_count. All values are sampled in the decode cycle.
- Any other byte, by mode:
  - ECHO: the byte itself.
  - FIXED: 0x42.
  - COUNTER: current counter value, then counter+1 (wraps 0xFF→0x00).
  - PATTERN: pattern register, then toggle 0x55↔0xAA.
- Push FSM states:
  - P_IDLE → P_DECODE on an accepted byte.
  - P_DECODE → P_PUSH.
  - P_PUSH holds for N cycles (N=1, or 4 for 'S'), then returns to P_IDLE.
- Byte arriving while the push FSM is not idle: stored in a 1-entry pending slot and decoded on return to P_IDLE.
- Byte arriving while the pending slot is occupied: dropped, overflow=1.
- FIFO full on push: the byte is dropped, overflow=1, and the sequence continues with the next byte.
- Push and pop in the same cycle when full: pop is applied first, so the push is accepted.
- TX FSM states:
  - T_IDLE: if FIFO non-empty && !tx_busy, pop the head into tx_data, assert tx_send for exactly 1 cycle, go to T_WAIT.
  - T_WAIT: return to T_IDLE on tx_done.
- TX latency: the byte at the FIFO head in cycle n gives tx_send=1 in cycle n+1 when the transmitter is idle.
- tx_data holds its value until the next pop.
- Heartbeat: a cycle counter counts 0..HB_PERIOD-1 and pulses at wrap. On the pulse, push 'H' (0x48) only if the push FSM is idle, no byte is accepted in that cycle, and the FIFO is empty. Otherwise the heartbeat is skipped; it is never queued.
- Reset asserted mid-operation: immediate return to reset values. A byte in flight in the transmitter is not tracked.

Optional Feature:
- Macro: UART_CMD_HEARTBEAT_EN.
- Defined: heartbeat counter and 'H' emission exist as described above.
- Undefined: no heartbeat counter is instantiated and 'H' is never generated. HB_PERIOD is ignored. All other behaviour is identical.

Test Plan:
- Reset, then send 'P' → exactly one tx_send with tx_data=0x4F; fifo_level returns to 0; busy=0.
- Send 'C', then 0x10 three times → responses 'A', 0x00, 0x01, 0x02; then 'S' → 0x53, 0x02, 0x03, 0x00.
- Send 'T', then 0x00 three times → 'A', 0x55, 0xAA, 0x55; mode=3.
- Two rx_error strobes, then 'S' → err_count=2 in the 4th byte; 'R' → 'A', err_count=0.
- Hold tx_busy=1 and send 'S' three times (12 bytes, FIFO_DEPTH=8) → 8 bytes queued, overflow=1; release tx_busy → first 8 bytes transmitted in order.
- With HB_PERIOD=100 and the macro defined, idle for 250 cycles → 'H' pushed at cycles 100 and 200. With an 'S' queue pending at a pulse → no 'H' emitted. With the macro undefined → no 'H' at all.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
//   Byte-level command/response engine between a UART receiver and
//   transmitter. Received bytes are decoded by a push FSM. Each response
//   byte goes into a TX FIFO. A TX FSM drains the FIFO, one byte per
//   transmitter handshake.
//
//   Optional macro UART_CMD_HEARTBEAT_EN: when it is defined, a periodic
//   'H' (0x48) heartbeat byte is emitted while the engine is quiet.
//
// Ports
//   clk, reset          system clock, async active-high reset
//   rx_data/valid/error received byte, strobe, framing-error qualifier
//   tx_data/tx_send     byte to send, one-cycle send request
//   tx_busy/tx_done     transmitter busy level, one-cycle done strobe
//   mode                0=ECHO 1=FIXED 2=COUNTER 3=PATTERN
//   fifo_level          TX FIFO occupancy
//   overflow            sticky: a response or received byte was dropped
//   err_count           saturating count of rx_error strobes
//   busy                engine not quiescent

module uart_cmd_responder #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int HB_PERIOD  = 50_000_000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          rx_error,
  output logic [7:0]                    tx_data,
  output logic                          tx_send,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic [1:0]                    mode,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    err_count,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  if (CLOCK_FREQ < 1) begin : g_bad_clk
    $error("CLOCK_FREQ must be positive");
  end
  if (HB_PERIOD < 2) begin : g_bad_hb
    $error("HB_PERIOD must be at least 2");
  end
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 4");
  end

  typedef enum logic [1:0] {P_IDLE, P_DECODE, P_PUSH} p_state_t;
  typedef enum logic {T_IDLE, T_WAIT} t_state_t;

  p_state_t        p_state_q, p_state_d;
  t_state_t        t_state_q, t_state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      pend_q, pend_d;
  logic            pend_valid_q, pend_valid_d;
  logic [3:0][7:0] resp_q, resp_d;
  logic [1:0]      resp_last_q, resp_last_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      mode_q, mode_d;
  logic [7:0]      counter_q, counter_d;
  logic [7:0]      pattern_q, pattern_d;
  logic [7:0]      err_q, err_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_send_q, tx_send_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   count_q, count_d;

`ifdef UART_CMD_HEARTBEAT_EN
  localparam int HB_W = $clog2(HB_PERIOD);
  logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
  logic            hb_pulse;
`endif

  logic       accept, err_byte, fifo_empty, fifo_full, pop;
  logic       push_req, push_ok;
  logic [7:0] push_byte;
  logic       ovf_set, ovf_clr, err_clr;

  always_comb begin
    accept     = rx_valid & ~rx_error;
    err_byte   = rx_valid & rx_error;
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == LW'(FIFO_DEPTH));
    pop        = (t_state_q == T_IDLE) && !fifo_empty && !tx_busy;

    p_state_d    = p_state_q;
    cmd_d        = cmd_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    resp_d       = resp_q;
    resp_last_d  = resp_last_q;
    idx_d        = idx_q;
    mode_d       = mode_q;
    counter_d    = counter_q;
    pattern_d    = pattern_q;
    push_req     = 1'b0;
    push_byte    = 8'h00;
    ovf_set      = 1'b0;
    ovf_clr      = 1'b0;
    err_clr      = 1'b0;

    // Bytes that arrive while the push FSM is busy go to the pending slot.
    // A byte that arrives in P_IDLE is also parked there when the slot is
    // being drained in that same cycle.
    if (accept && (p_state_q != P_IDLE || pend_valid_q)) begin
      if (pend_valid_q && p_state_q != P_IDLE) begin
        ovf_set = 1'b1;
      end else begin
        pend_d       = rx_data;
        pend_valid_d = 1'b1;
      end
    end

    case (p_state_q)
      P_IDLE: begin
        if (pend_valid_q) begin
          cmd_d     = pend_q;
          p_state_d = P_DECODE;
          if (!accept) pend_valid_d = 1'b0;
        end else if (accept) begin
          cmd_d     = rx_data;
          p_state_d = P_DECODE;
        end
      end
      P_DECODE: begin
        resp_d      = '0;
        resp_last_d = 2'd0;
        idx_d       = 2'd0;
        p_state_d   = P_PUSH;
        case (cmd_q)
          8'h50: resp_d[0] = 8'h4F;
          8'h45: begin mode_d = 2'd0; resp_d[0] = 8'h41; end
          8'h46: begin mode_d = 2'd1; resp_d[0] = 8'h41; end
          8'h43: begin mode_d = 2'd2; resp_d[0] = 8'h41; end
          8'h54: begin mode_d = 2'd3; resp_d[0] = 8'h41; end
          8'h52: begin
            counter_d = 8'h00;
            err_clr   = 1'b1;
            ovf_clr   = 1'b1;
            resp_d[0] = 8'h41;
          end
          8'h53: begin
            resp_d      = {err_q, counter_q, {6'b0, mode_q}, 8'h53};
            resp_last_d = 2'd3;
          end
          default: begin
            case (mode_q)
              2'd0: resp_d[0] = cmd_q;
              2'd1: resp_d[0] = 8'h42;
              2'd2: begin
                resp_d[0] = counter_q;
                counter_d = counter_q + 8'd1;
              end
              default: begin
                resp_d[0] = pattern_q;
                pattern_d = ~pattern_q;  // 0x55 <-> 0xAA
              end
            endcase
          end
        endcase
      end
      P_PUSH: begin
        push_req  = 1'b1;
        push_byte = resp_q[idx_q];
        if (idx_q == resp_last_q) p_state_d = P_IDLE;
        else idx_d = idx_q + 2'd1;
      end
      default: p_state_d = P_IDLE;
    endcase

`ifdef UART_CMD_HEARTBEAT_EN
    hb_pulse = (hb_cnt_q == HB_W'(HB_PERIOD - 1));
    hb_cnt_d = hb_pulse ? '0 : hb_cnt_q + 1'b1;
    // Heartbeat only fills an otherwise silent line; a skipped one is lost.
    if (hb_pulse && p_state_q == P_IDLE && !pend_valid_q && !accept && fifo_empty) begin
      push_req  = 1'b1;
      push_byte = 8'h48;
    end
`endif

    // A pop in the same cycle frees the slot for a push into a full FIFO.
    push_ok = push_req && (!fifo_full || pop);
    if (push_req && !push_ok) ovf_set = 1'b1;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_byte;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + LW'(push_ok) - LW'(pop);

    t_state_d = t_state_q;
    tx_send_d = 1'b0;
    tx_data_d = tx_data_q;
    case (t_state_q)
      T_IDLE: begin
        if (pop) begin
          tx_data_d = mem_q[rd_ptr_q];
          tx_send_d = 1'b1;
          t_state_d = T_WAIT;
        end
      end
      default: if (tx_done) t_state_d = T_IDLE;
    endcase

    err_d = err_q;
    if (err_byte && err_q != 8'hFF) err_d = err_q + 8'd1;
    if (err_clr) err_d = 8'h00;

    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_state_q    <= P_IDLE;
      t_state_q    <= T_IDLE;
      cmd_q        <= 8'h00;
      pend_q       <= 8'h00;
      pend_valid_q <= 1'b0;
      resp_q       <= '0;
      resp_last_q  <= 2'd0;
      idx_q        <= 2'd0;
      mode_q       <= 2'd0;
      counter_q    <= 8'h00;
      pattern_q    <= 8'h55;
      err_q        <= 8'h00;
      ovf_q        <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_send_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
`ifdef UART_CMD_HEARTBEAT_EN
      hb_cnt_q     <= '0;
`endif
    end else begin
      p_state_q    <= p_state_d;
      t_state_q    <= t_state_d;
      cmd_q        <= cmd_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      resp_q       <= resp_d;
      resp_last_q  <= resp_last_d;
      idx_q        <= idx_d;
      mode_q       <= mode_d;
      counter_q    <= counter_d;
      pattern_q    <= pattern_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
      tx_data_q    <= tx_data_d;
      tx_send_q    <= tx_send_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
`ifdef UART_CMD_HEARTBEAT_EN
      hb_cnt_q     <= hb_cnt_d;
`endif
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_send    = tx_send_q;
  assign mode       = mode_q;
  assign fifo_level = count_q;
  assign overflow   = ovf_q;
  assign err_count  = err_q;
  assign busy       = (p_state_q != P_IDLE) || pend_valid_q ||
                      (t_state_q != T_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder. A small transmitter model
// acknowledges every tx_send after a few cycles and records the bytes.
module tb_uart_cmd_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_error = 1'b0;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy;
  logic       tx_done = 1'b0;
  logic [1:0] mode;
  logic [3:0] fifo_level;
  logic       overflow;
  logic [7:0] err_count;
  logic       busy;

  logic       busy_m = 1'b0;
  logic       hold_busy = 1'b0;
  int         tx_cnt = 0;
  logic       prev_send = 1'b0;
  int         double_send = 0;
  logic [7:0] got_q[$];

  int checks = 0;
  int failures = 0;

  assign tx_busy = busy_m | hold_busy;

  uart_cmd_responder #(
    .CLOCK_FREQ(100),
    .HB_PERIOD (100),
    .FIFO_DEPTH(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_error  (rx_error),
    .tx_data   (tx_data),
    .tx_send   (tx_send),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .mode      (mode),
    .fifo_level(fifo_level),
    .overflow  (overflow),
    .err_count (err_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for 3 cycles after each send, then done strobe.
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (tx_send && prev_send) double_send++;
    prev_send = tx_send;
    if (reset) begin
      tx_cnt = 0;
      busy_m = 1'b0;
    end else if (tx_send) begin
      got_q.push_back(tx_data);
      tx_cnt = 3;
      busy_m = 1'b1;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_done = 1'b1;
        busy_m  = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    got_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_error = err;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({name, "_timeout"}, 1, 0);
  endtask

  // Heartbeat bytes may interleave when the feature is built in.
  task automatic filter_h();
`ifdef UART_CMD_HEARTBEAT_EN
    for (int i = got_q.size() - 1; i >= 0; i--)
      if (got_q[i] == 8'h48) got_q.delete(i);
`endif
  endtask

  function automatic int got_at(input int j);
    if (j < got_q.size()) return int'(got_q[j]);
    return -1;
  endfunction

  typedef struct {
    logic [7:0]  cmd;
    logic        err;
    int          n;
    logic [31:0] e;    // expected bytes, first in [31:24]
    logic [1:0]  m;
    logic [7:0]  ec;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  initial begin
    vecs[0]  = '{8'h50, 1'b0, 1, 32'h4F000000, 2'd0, 8'd0};
    vecs[1]  = '{8'h43, 1'b0, 1, 32'h41000000, 2'd2, 8'd0};
    vecs[2]  = '{8'h10, 1'b0, 1, 32'h00000000, 2'd2, 8'd0};
    vecs[3]  = '{8'h10, 1'b0, 1, 32'h01000000, 2'd2, 8'd0};
    vecs[4]  = '{8'h10, 1'b0, 1, 32'h02000000, 2'd2, 8'd0};
    vecs[5]  = '{8'h53, 1'b0, 4, 32'h53020300, 2'd2, 8'd0};
    vecs[6]  = '{8'h54, 1'b0, 1, 32'h41000000, 2'd3, 8'd0};
    vecs[7]  = '{8'h00, 1'b0, 1, 32'h55000000, 2'd3, 8'd0};
    vecs[8]  = '{8'h00, 1'b0, 1, 32'hAA000000, 2'd3, 8'd0};
    vecs[9]  = '{8'h00, 1'b0, 1, 32'h55000000, 2'd3, 8'd0};
    vecs[10] = '{8'h00, 1'b1, 0, 32'h00000000, 2'd3, 8'd1};
    vecs[11] = '{8'h53, 1'b1, 0, 32'h00000000, 2'd3, 8'd2};
    vecs[12] = '{8'h53, 1'b0, 4, 32'h53030302, 2'd3, 8'd2};
    vecs[13] = '{8'h52, 1'b0, 1, 32'h41000000, 2'd3, 8'd0};
    vecs[14] = '{8'h53, 1'b0, 4, 32'h53030000, 2'd3, 8'd0};
    vecs[15] = '{8'h46, 1'b0, 1, 32'h41000000, 2'd1, 8'd0};
    vecs[16] = '{8'h77, 1'b0, 1, 32'h42000000, 2'd1, 8'd0};
    vecs[17] = '{8'h45, 1'b0, 1, 32'h41000000, 2'd0, 8'd0};
    vecs[18] = '{8'h5A, 1'b0, 1, 32'h5A000000, 2'd0, 8'd0};

    do_reset();
    @(negedge clk);
    chk("rst_tx_send", tx_send, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_mode", mode, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_busy", busy, 0);

    for (int i = 0; i < NV; i++) begin
      got_q.delete();
      send_byte(vecs[i].cmd, vecs[i].err);
      wait_idle($sformatf("v%0d", i), 200);
      filter_h();
      chk($sformatf("v%0d_nbytes", i), got_q.size(), vecs[i].n);
      for (int j = 0; j < vecs[i].n; j++)
        chk($sformatf("v%0d_byte%0d", i, j), got_at(j), int'(vecs[i].e[31-8*j -: 8]));
      chk($sformatf("v%0d_mode", i), mode, vecs[i].m);
      chk($sformatf("v%0d_err_count", i), err_count, vecs[i].ec);
      chk($sformatf("v%0d_fifo_level", i), fifo_level, 0);
      chk($sformatf("v%0d_overflow", i), overflow, 0);
    end

    // Back-to-back bytes: second is held in the pending slot, third dropped.
    got_q.delete();
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h31;
    @(negedge clk);
    rx_data  = 8'h32;
    @(negedge clk);
    rx_data  = 8'h33;
    @(negedge clk);
    rx_valid = 1'b0;
    wait_idle("pend", 200);
    filter_h();
    chk("pend_nbytes", got_q.size(), 2);
    chk("pend_byte0", got_at(0), 8'h31);
    chk("pend_byte1", got_at(1), 8'h32);
    chk("pend_overflow", overflow, 1);

    // FIFO overflow with the transmitter held busy.
    do_reset();
    hold_busy = 1'b1;
    send_byte(8'h54, 1'b0);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      send_byte(8'h53, 1'b0);
      repeat (6) @(negedge clk);
    end
    chk("full_fifo_level", fifo_level, 8);
    chk("full_overflow", overflow, 1);
    chk("full_no_send", got_q.size(), 0);
    hold_busy = 1'b0;
    wait_idle("full_drain", 400);
    filter_h();
    chk("full_nbytes", got_q.size(), 8);
    chk("full_b0", got_at(0), 8'h41);
    chk("full_b1", got_at(1), 8'h53);
    chk("full_b2", got_at(2), 8'h03);
    chk("full_b3", got_at(3), 8'h00);
    chk("full_b4", got_at(4), 8'h00);
    chk("full_b5", got_at(5), 8'h53);
    chk("full_b6", got_at(6), 8'h03);
    chk("full_b7", got_at(7), 8'h00);
    chk("full_level_after", fifo_level, 0);
    chk("full_overflow_sticky", overflow, 1);
    got_q.delete();
    send_byte(8'h52, 1'b0);
    wait_idle("clr", 200);
    filter_h();
    chk("clr_byte", got_at(0), 8'h41);
    chk("clr_overflow", overflow, 0);

    // Heartbeat behaviour on a quiet line.
    do_reset();
    repeat (250) @(negedge clk);
`ifdef UART_CMD_HEARTBEAT_EN
    chk("hb_count", got_q.size(), 2);
    chk("hb_b0", got_at(0), 8'h48);
    chk("hb_b1", got_at(1), 8'h48);
    do_reset();
    hold_busy = 1'b1;
    send_byte(8'h53, 1'b0);
    repeat (148) @(negedge clk);
    chk("hb_skip_level", fifo_level, 4);
    hold_busy = 1'b0;
    wait_idle("hb_skip", 200);
`else
    chk("hb_none", got_q.size(), 0);
    chk("hb_none_busy", busy, 0);
`endif

    chk("single_cycle_send", double_send, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
